// File: rtl/muldiv_unit_if.sv
// Host-side handshake bundle for the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, flush, input busy, done, result);
  modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per cycle with a start/busy/done handshake and flush kill.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CW  = $clog2(XLEN) + 1;
  localparam int unsigned AW  = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            is_div, is_div_d;
  logic            sel_q, sel_d;
  logic            neg_q, neg_q_d;
  logic            neg_r, neg_r_d;
  logic [XLEN-1:0] mag_b, mag_b_d;
  logic [XLEN-1:0] result, result_d;
  logic [AW-1:0]   acc, acc_d;

  // Operand signedness and magnitudes of the incoming request
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  assign a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                    (bus.op == 3'b100) || (bus.op == 3'b110);
  assign b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
  assign sa       = a_signed & bus.a[XLEN-1];
  assign sb       = b_signed & bus.b[XLEN-1];
  assign mag_a_in = sa ? -bus.a : bus.a;
  assign mag_b_in = sb ? -bus.b : bus.b;

  // One iteration step; acc is {hi, lo} = {product hi, multiplier} or {remainder, quotient}
  logic [XLEN:0]   mul_sum, div_trial;
  logic [AW-1:0]   step_acc, signed_prod;
  logic [XLEN-1:0] quo_part, rem_part, fin_val;

  always_comb begin
    mul_sum     = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
    div_trial   = {acc[AW-1:XLEN], acc[XLEN-1]} - {1'b0, mag_b};
    step_acc    = {mul_sum, acc[XLEN-1:1]};
    if (is_div) begin
      step_acc = div_trial[XLEN] ? {acc[AW-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
    signed_prod = neg_q ? -step_acc : step_acc;
    quo_part    = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem_part    = neg_r ? -step_acc[AW-1:XLEN] : step_acc[AW-1:XLEN];
    if (is_div) fin_val = sel_q ? rem_part : quo_part;
    else        fin_val = sel_q ? signed_prod[AW-1:XLEN] : signed_prod[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sel_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mag_b  <= '0;
      result <= '0;
      acc    <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      is_div <= is_div_d;
      sel_q  <= sel_d;
      neg_q  <= neg_q_d;
      neg_r  <= neg_r_d;
      mag_b  <= mag_b_d;
      result <= result_d;
      acc    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    is_div_d = is_div;
    sel_d    = sel_q;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    mag_b_d  = mag_b;
    result_d = result;
    acc_d    = acc;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[2];
          sel_d    = bus.op[2] ? bus.op[1] : (bus.op[1:0] != 2'b00);
          neg_q_d  = sa ^ sb;
          neg_r_d  = sa;
          mag_b_d  = mag_b_in;
          acc_d    = {{XLEN{1'b0}}, mag_a_in};
          if (bus.op[2] && (bus.b == '0)) begin
            result_d = bus.op[1] ? bus.a : '1;
            state_d  = FIN;
          end else if (bus.op[2] && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1)) begin
            result_d = bus.op[1] ? '0 : bus.a;
            state_d  = FIN;
          end else begin
            cnt_d   = CW'(XLEN);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt - CW'(1);
        // Result lands on entry to FIN so it is valid alongside done
        if (cnt == CW'(1)) begin
          result_d = fin_val;
          state_d  = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == FIN);
  assign bus.result = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32- and 16-bit instances checked every cycle against a timeline model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0;
  logic        start16 = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus32();
  muldiv_unit_if #(.XLEN(16)) bus16();

  assign bus32.start = start32;
  assign bus32.op    = op;
  assign bus32.a     = a;
  assign bus32.b     = b;
  assign bus32.flush = flush;
  assign bus16.start = start16;
  assign bus16.op    = op;
  assign bus16.a     = a[15:0];
  assign bus16.b     = b[15:0];
  assign bus16.flush = flush;

  muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic for an M-extension op at width w (w <= 32)
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
    longint m, ux, uy, sx, sy, r, mn;
    longint unsigned pu;
    m  = (longint'(1) << w) - 1;
    mn = -(longint'(1) << (w - 1));
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    sx = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
    sy = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
    r  = 0;
    case (o)
      3'd0: r = ux * uy;
      3'd1: r = (sx * sy) >>> w;
      3'd2: r = (sx * uy) >>> w;
      3'd3: begin pu = ux * uy; r = longint'(pu >> w); end
      3'd4: begin
        if (uy == 0) r = -1;
        else if (sx == mn && sy == -1) r = sx;
        else r = sx / sy;
      end
      3'd5: begin if (uy == 0) r = m; else r = ux / uy; end
      3'd6: begin
        if (uy == 0) r = sx;
        else if (sx == mn && sy == -1) r = 0;
        else r = sx % sy;
      end
      default: begin if (uy == 0) r = ux; else r = ux % uy; end
    endcase
    return 32'(r & m);
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x,
                                    input logic [31:0] y, input int w);
    longint m, ux, uy;
    m  = (longint'(1) << w) - 1;
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    return o[2] && (uy == 0 || (!o[0] && ux == (longint'(1) << (w - 1)) && uy == m));
  endfunction

  // Timeline model: remaining busy cycles and the architecturally visible result
  int          rem_c[2] = '{0, 0};
  logic [31:0] mres[2]  = '{32'h0, 32'h0};
  logic [31:0] pend[2]  = '{32'h0, 32'h0};
  int          mw;
  logic        mst;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mw  = (k == 0) ? 32 : 16;
      mst = (k == 0) ? start32 : start16;
      if (reset) begin
        rem_c[k] = 0;
        mres[k]  = 32'h0;
      end else if (flush) begin
        rem_c[k] = 0;
      end else if (rem_c[k] > 0) begin
        rem_c[k]--;
        if (rem_c[k] == 1) mres[k] = pend[k];
      end else if (mst) begin
        pend[k]  = ref_res(op, a, b, mw);
        rem_c[k] = is_special(op, a, b, mw) ? 1 : mw + 1;
        if (rem_c[k] == 1) mres[k] = pend[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy32",   32'(bus32.busy),   32'(rem_c[0] > 0));
      chk("done32",   32'(bus32.done),   32'(rem_c[0] == 1));
      chk("result32", bus32.result,      mres[0]);
      chk("busy16",   32'(bus16.busy),   32'(rem_c[1] > 0));
      chk("done16",   32'(bus16.done),   32'(rem_c[1] == 1));
      chk("result16", 32'(bus16.result), mres[1]);
    end
  end

  // Issue one op, hold start through FIN, check literal result, latency and single done
  task automatic run(input int sel, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int lat,
                     input string name);
    int   cyc;
    int   nd;
    logic d;
    cyc = 0;
    @(negedge clk);
    op = o; a = x; b = y;
    if (sel == 0) start32 = 1'b1; else start16 = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      d = (sel == 0) ? bus32.done : bus16.done;
    end while (!d && cyc < 200);
    chk({name, "_lat"}, 32'(cyc), 32'(lat));
    chk({name, "_res"}, (sel == 0) ? bus32.result : 32'(bus16.result), exp);
    nd = d ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        @(negedge clk);
        start32 = 1'b0;
        start16 = 1'b0;
      end
      if ((sel == 0) ? bus32.done : bus16.done) nd++;
    end
    chk({name, "_ndone"}, 32'(nd), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy32",   32'(bus32.busy), 32'd0);
    chk("rst_done32",   32'(bus32.done), 32'd0);
    chk("rst_result32", bus32.result,    32'd0);
    chk_en = 1'b1;
    reset  = 1'b0;

    run(0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    run(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
    run(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div");
    run(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem");
    run(0, 3'd5, 32'd100,      32'd7,        32'd14,       33, "divu");
    run(0, 3'd7, 32'd100,      32'd7,        32'd2,        33, "remu");
    run(0, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu0");
    run(0, 3'd6, 32'd5,        32'd0,        32'd5,        1,  "rem0");
    run(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "divovf");
    run(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "removf");

    // Flush on the 10th CALC cycle
    @(negedge clk);
    op = 3'd0; a = 32'h12345678; b = 32'h9ABCDEF1; start32 = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_flush_busy", 32'(bus32.busy), 32'd1);
    flush = 1'b1; start32 = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(bus32.busy), 32'd0);
    chk("flush_result", bus32.result, 32'd0);
    flush = 1'b0;
    run(0, 3'd5, 32'd9, 32'd3, 32'd3, 33, "divu_after_flush");

    // Flush together with start in IDLE is not accepted
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd4; start32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_busy", 32'(bus32.busy), 32'd0);
    start32 = 1'b0; flush = 1'b0;

    // Reset in the middle of CALC
    @(negedge clk);
    op = 3'd3; a = 32'hDEADBEEF; b = 32'h01234567; start32 = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start32 = 1'b0;
    chk("midrst_busy",   32'(bus32.busy), 32'd0);
    chk("midrst_result", bus32.result,    32'd0);

    run(1, 3'd0, 32'h000000FF, 32'h00000101, 32'h0000FFFF, 17, "mul16");
    run(1, 3'd4, 32'h00008000, 32'h0000FFFF, 32'h00008000, 1,  "div16ovf");
    run(1, 3'd4, 32'h0000FFF9, 32'h00000002, 32'h0000FFFD, 17, "div16");
    run(1, 3'd7, 32'h0000FFF9, 32'h00000010, 32'h00000009, 17, "remu16");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width, attached beside the main ALU in the EX stage of the 5-stage pipeline. Accepts one M-extension operation at a time (funct3-encoded) with forwarded operands. Computes it over multiple cycles with a start/busy/done handshake, so the hazard logic can stall ID/EX while it works. Supports a flush input that kills in-flight work on control-flow redirects.

## Interface
Parameters:
- XLEN, 32: operand/result width; any value ≥ 4; iteration counter is clog2(XLEN)+1 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock, same as core.
- start  in  1  request; sampled only in IDLE; host holds it and operands stable until done.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand (post-forwarding).
- b  in  XLEN  rs2 operand (post-forwarding).
- flush  in  1  kill current operation; priority over start.
- busy  out  1  high in CALC and FIN; host stalls EX while busy & ~done.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  registered result; holds last value until next done.

## Operation
- States: IDLE, CALC, FIN. Reset → IDLE; busy=0, done=0, result=0, counter=0.
- IDLE & start & ~flush: latch op, a, b; compute sign flags (signed a for MULH/MULHSU/DIV/REM; signed b for MULH/DIV/REM), take magnitudes (two's-complement negate if signed and negative).
  - Special case → FIN directly: DIV/DIVU with b=0 (quotient all-ones, REM/REMU result = a); DIV/REM with a=most-negative and b=−1 (DIV result = a, REM result = 0).
  - Otherwise → CALC, counter = XLEN.
- CALC, multiply: radix-2 shift-add into 2·XLEN-bit accumulator, one multiplier bit per cycle. Final product negated if sign(a)≠sign(b) under the signedness rules. MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- CALC, divide: restoring, one quotient bit per cycle on (XLEN+1)-bit partial remainder. Quotient negated if sa≠sb; remainder takes sign of a. DIV/DIVU return quotient; REM/REMU return remainder.
- Counter decrements each CALC cycle; at 1 → FIN. FIN: result register written, done=1, → IDLE next cycle.
- start asserted in CALC or FIN is ignored, so no re-issue while the host releases start.
- flush in any state → IDLE next edge; no done; result unchanged. flush & start in IDLE: not accepted.
- reset mid-operation: same as flush, plus result cleared to 0.
- All arithmetic is modulo 2^XLEN; internal intermediates use 2·XLEN bits for multiply and XLEN+1 bits for divide.

## Timing
- start sampled at edge ending cycle T.
- Normal op: CALC for cycles T+1..T+XLEN; FIN (done=1) in T+XLEN+1; IDLE at T+XLEN+2. Latency XLEN+1.
- Special case: FIN in T+1; latency 1.
- busy combinationally equals (state≠IDLE); done equals (state==FIN); result is driven from a register.
- Back-to-back: a new start is accepted in the first IDLE cycle after FIN, so throughput is one op per XLEN+2 cycles.
- flush in cycle C → state IDLE in C+1, busy=0 in C+1.

## Test plan
- XLEN=32, MUL a=7 b=0xFFFFFFFD → result 0xFFFFFFEB; done exactly 33 cycles after start sampled; busy high 33 cycles.
- Multiply-high: MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide signs: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; each with done 1 cycle after start.
- Flush/reset: assert flush in 10th CALC cycle → no done, busy 0 next cycle, then DIVU 9/3 → 3. Assert reset mid-CALC → result 0, busy 0; start held through FIN → exactly one done.
- XLEN=16 instance: MUL 0x00FF×0x0101 → 0xFFFF with done 17 cycles after start; DIV 0x8000/0xFFFF → 0x8000.
